// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state type, oversample factor, data width.
// No logic of its own beyond a parity helper; no latency.
// No flow control here; users apply their own handshakes.
package uart_pkg;

    // Oversample ticks per bit period and payload width
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    // Terminal values for the tick counter and the data bit index
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    // Transmit FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Parity bit for a byte: even parity is the XOR of the bits, odd inverts it
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit framer: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Line level follows accept by one cycle; each bit lasts 16 tx_tick pulses.
// tx_ready only in IDLE; tx_valid while busy is ignored, so the byte is held upstream.
module uart_tx_ctrl
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_tick,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_stop2,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Current state and per-bit bookkeeping
    uart_tx_state_t         r_state;
    logic [3:0]             r_tick_cnt;
    logic [2:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;

    // Frame configuration captured at accept so later input changes cannot disturb it
    logic                   r_par_en;
    logic                   r_par_bit;
    logic                   r_stop2;

    // Registered serial line so the pin never glitches on decode hazards
    logic                   r_tx;

    // Next-state values
    uart_tx_state_t         w_state_nxt;
    logic [3:0]             w_tick_cnt_nxt;
    logic [2:0]             w_bit_idx_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic                   w_tx_nxt;
    logic                   w_done;

    // Handshake and bit-period decode
    logic                   w_accept;
    logic                   w_bit_end;

    assign w_accept  = (r_state == IDLE) && tx_valid;
    assign w_bit_end = (r_state != IDLE) && tx_tick && (r_tick_cnt == TICK_LAST);

    // Next-state logic: tick counting, bit sequencing and the line level for the next cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_done         = 1'b0;
        w_tx_nxt       = 1'b1;

        // Ticks only count inside a frame; the accept-cycle tick falls in IDLE and is dropped
        if (r_state != IDLE && tx_tick) begin
            w_tick_cnt_nxt = w_bit_end ? 4'd0 : r_tick_cnt + 4'd1;
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = START;
                    w_tick_cnt_nxt = 4'd0;
                    w_bit_idx_nxt  = 3'd0;
                    w_shift_nxt    = tx_data;
                end
            end

            START: begin
                if (w_bit_end) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = 3'd0;
                end
            end

            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == BIT_LAST) begin
                        w_state_nxt   = r_par_en ? PARITY : STOP;
                        w_bit_idx_nxt = 3'd0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end
            end

            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt   = STOP;
                    w_bit_idx_nxt = 3'd0;
                end
            end

            STOP: begin
                // Bit index doubles as the stop-bit counter for two-stop-bit frames
                if (w_bit_end) begin
                    if (r_stop2 && r_bit_idx == 3'd0) begin
                        w_bit_idx_nxt = 3'd1;
                    end else begin
                        w_state_nxt   = IDLE;
                        w_bit_idx_nxt = 3'd0;
                        w_done        = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt    = IDLE;
                w_tick_cnt_nxt = 4'd0;
                w_bit_idx_nxt  = 3'd0;
            end
        endcase

        // Line level belonging to the state entered at the next edge
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = r_par_bit;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // State register with synchronous reset; configuration is captured only on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            if (w_accept) begin
                r_par_en  <= cfg_parity_en;
                r_par_bit <= parity_bit(tx_data, cfg_parity_odd);
                r_stop2   <= cfg_stop2;
            end
        end
    end

    // Status outputs; done is masked by reset so an aborted frame never reports completion
    assign tx_ready = (r_state == IDLE);
    assign tx_busy  = (r_state != IDLE);
    assign tx_done  = w_done && !rst;
    assign tx       = r_tx;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have one clock `clk` and one reset `rst`; `rst` is synchronous and active-high.
REQ-002 Port list SHALL be exactly as follows, clock and reset first:
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `tx_tick` in 1: one-cycle pulse at 16x the baud rate, from the baud generator.
- `cfg_parity_en` in 1: 1 = append a parity bit.
- `cfg_parity_odd` in 1: 1 = odd parity, 0 = even parity.
- `cfg_stop2` in 1: 1 = two stop bits, 0 = one stop bit.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: the byte on `tx_data` is offered.
- `tx_ready` out 1: the block can accept a byte.
- `tx` out 1: serial line, idle high.
- `tx_busy` out 1: a frame is in progress.
- `tx_done` out 1: one-cycle pulse at the end of a frame.
REQ-003 The block SHALL have no parameters; the oversample factor is the package constant `OVERSAMPLE` = 16.

Function
REQ-004 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-005 `tx_ready` SHALL be 1 only in IDLE; `tx_busy` SHALL be 1 in every state except IDLE.
REQ-006 Accept rule:
- A byte is accepted in the cycle where `tx_valid` and `tx_ready` are both 1.
- On accept, `tx_data`, `cfg_parity_en`, `cfg_parity_odd` and `cfg_stop2` SHALL be latched.
- The next cycle enters START.
REQ-007 Config or data changes after accept SHALL NOT affect the frame in progress.
REQ-008 A 4-bit tick counter SHALL count `tx_tick` pulses:
- It resets to 0 on every state or bit change.
- A bit ends on the 16th tick counted in that bit.
REQ-009 A `tx_tick` in the accept cycle SHALL be ignored; counting starts in the first START cycle.
REQ-010 Line levels per state:
- START: `tx` = 0.
- DATA: `tx` = current data bit, LSB first, 8 bits, tracked by a 3-bit index.
- PARITY: `tx` = XOR of the latched byte, inverted when the latched odd flag is 1.
- STOP: `tx` = 1.
- IDLE: `tx` = 1.
REQ-011 Transitions:
- START -> DATA.
- DATA (after bit 7) -> PARITY if the latched parity enable is 1, else STOP.
- PARITY -> STOP.
- STOP -> IDLE after 1 or 2 bit periods, per the latched stop flag.
REQ-012 `tx_done` SHALL pulse for exactly one cycle, in the cycle where STOP exits to IDLE.
REQ-013 Back-to-back frames: `tx_ready` SHALL be 1 in the cycle after `tx_done`. No extra idle bit is inserted.
REQ-014 `tx_valid` while busy SHALL be ignored; no byte is lost or duplicated.
REQ-015 `tx` SHALL be driven from a register (glitch-free).
REQ-016 Frame length SHALL be (10 + parity + extra stop) x 16 ticks. START may be shortened by up to one tick period due to tick phase.

Reset
REQ-017 While `rst` = 1 at a clock edge, the following SHALL hold after that edge:
- state = IDLE.
- `tx` = 1, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0.
- Tick counter, bit index and shift register = 0.
REQ-018 A reset mid-frame SHALL abort the frame:
- `tx` is high at the first edge after reset.
- No `tx_done` is generated.
REQ-019 Ticks and `tx_valid` during reset SHALL be ignored.

Structure
REQ-020 Shared package `uart_pkg` SHALL hold:
- The state enum type `uart_tx_state_t`.
- `OVERSAMPLE` = 16.
- `DATA_BITS` = 8.
REQ-021 No sub-module SHALL be used. The tick source is the baud generator, instantiated by the parent, with its `tx_tick` wired to this block.
REQ-022 The block SHALL be a single sequential FSM process plus combinational next-state and output logic.

Verification
REQ-023 Basic frame:
- Stimulus: 0xA5, no parity, 1 stop.
- Response: `tx` bit sequence 0,1,0,1,0,0,1,0,1,1; `tx_done` after 160 ticks.
REQ-024 Parity and two stop bits:
- Stimulus: 0xA5, even parity, 2 stop.
- Response: parity bit 0; 12 bit periods; `tx_done` after 192 ticks.
- Repeat with odd parity: parity bit 1.
REQ-025 Back-to-back with config change:
- Stimulus: `tx_valid` held with 0x00 then 0xFF; change `cfg_parity_en` mid-frame.
- Response: the second frame starts in the cycle after `tx_done`+1; the first frame keeps its latched config.
REQ-026 Mid-frame reset:
- Stimulus: assert `rst` during DATA bit 3.
- Response: `tx` = 1, `tx_ready` = 1, `tx_done` = 0 after the edge; a new 0x3C frame then transmits correctly.
REQ-027 Tick on accept:
- Stimulus: `tx_tick` coincident with the accept cycle.
- Response: the tick is not counted; the start bit ends on the 16th later tick.
REQ-028 Valid while busy:
- Stimulus: `tx_valid` pulsed while `tx_busy` = 1.
- Response: no accept, frame unaffected, `tx_ready` stays 0.
